// File: rtl/simon_pkg.sv
// Shared types and helpers for the Simon game core: FSM state encoding,
// mode LED codes and the pattern validity rule.
package simon_pkg;

   typedef enum logic [2:0] {
      INPUT    = 3'd0,
      PLAYBACK = 3'd1,
      REPEAT   = 3'd2,
      DONE     = 3'd3,
      WIN      = 3'd4
   } state_t;

   localparam logic [2:0] LED_MODE_INPUT    = 3'b001;
   localparam logic [2:0] LED_MODE_PLAYBACK = 3'b010;
   localparam logic [2:0] LED_MODE_REPEAT   = 3'b100;
   localparam logic [2:0] LED_MODE_DONE     = 3'b111;
   localparam logic [2:0] LED_MODE_WIN      = 3'b011;

   // Patterns are zero-extended to this width before validation.
   localparam int PAT_MAX_W = 32;

   // Easy: any nonzero pattern. Hard: exactly one switch up.
   function automatic logic valid_pattern(input logic                 level,
                                          input logic [PAT_MAX_W-1:0] pattern);
      logic ok;
      if (pattern == '0)
         ok = 1'b0;
      else if (!level)
         ok = 1'b1;
      else
         ok = ((pattern & (pattern - PAT_MAX_W'(1))) == '0);
      return ok;
   endfunction

endpackage

// File: rtl/simon_seq_mem.sv
// Sequence memory: DEPTH x WIDTH register array, one synchronous write
// port and one asynchronous read port.
module simon_seq_mem
   import simon_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 64,
   localparam int AW    = $clog2(DEPTH)
) (
   input  logic             pclk,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // NOTE: no reset on the array; entries are only read after being written.
   always_ff @(posedge pclk) begin
      if (we)
         mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/simon_multi.sv
// Simon game core: record, play back and check switch patterns.
// Optional high-score output enabled by defining SIMON_HISCORE_EN.
module simon_multi
   import simon_pkg::*;
#(
   parameter  int WIDTH = 4,
   parameter  int DEPTH = 64,
   parameter  int LIVES = 0,
   localparam int SW    = $clog2(DEPTH + 1),
   localparam int LW    = (LIVES > 0) ? $clog2(LIVES + 1) : 1
) (
   input  logic             pclk,
   input  logic             rst,
   input  logic             new_game,
   input  logic             level,
   input  logic [WIDTH-1:0] pattern,
   output logic [WIDTH-1:0] pattern_leds,
   output logic [2:0]       mode_leds,
   output logic [SW-1:0]    score,
   output logic [LW-1:0]    lives_left
`ifdef SIMON_HISCORE_EN
   ,
   output logic [SW-1:0]    hiscore
`endif
);

   localparam int IW = $clog2(DEPTH);

   state_t           state, state_nxt;
   logic [SW-1:0]    len, len_nxt;
   logic [IW-1:0]    idx, idx_nxt;
   logic [LW-1:0]    lives, lives_nxt;
   logic             mem_we;
   logic [WIDTH-1:0] mem_rdata;
   logic             at_last, is_full, pat_ok;

   simon_seq_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_mem (
      .pclk  (pclk),
      .we    (mem_we),
      .waddr (len[IW-1:0]),
      .wdata (pattern),
      .raddr (idx),
      .rdata (mem_rdata)
   );

   assign at_last = (SW'(idx) == (len - SW'(1)));
   assign is_full = (len == SW'(DEPTH));
   assign pat_ok  = valid_pattern(level, PAT_MAX_W'(pattern));

   // NOTE: non-blocking assignments for all state so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge pclk or negedge rst) begin
      if (!rst) begin
         state <= INPUT;
         len   <= '0;
         idx   <= '0;
         lives <= LW'(LIVES);
      end else begin
         state <= state_nxt;
         len   <= len_nxt;
         idx   <= idx_nxt;
         lives <= lives_nxt;
      end
   end

   // NOTE: every output of this block is defaulted first so no latch is inferred.
   always_comb begin
      state_nxt = state;
      len_nxt   = len;
      idx_nxt   = idx;
      lives_nxt = lives;
      mem_we    = 1'b0;
      if (new_game) begin
         state_nxt = INPUT;
         len_nxt   = '0;
         idx_nxt   = '0;
         lives_nxt = LW'(LIVES);
      end else begin
         case (state)
            INPUT: begin
               if (pat_ok && !is_full) begin
                  mem_we    = 1'b1;
                  len_nxt   = len + SW'(1);
                  idx_nxt   = '0;
                  state_nxt = PLAYBACK;
               end
            end
            PLAYBACK: begin
               if (at_last) begin
                  idx_nxt   = '0;
                  state_nxt = REPEAT;
               end else begin
                  idx_nxt = idx + IW'(1);
               end
            end
            REPEAT: begin
               if (pattern == mem_rdata) begin
                  if (at_last) begin
                     idx_nxt   = '0;
                     state_nxt = is_full ? WIN : INPUT;
                  end else begin
                     idx_nxt = idx + IW'(1);
                  end
               end else if (lives != '0) begin
                  lives_nxt = lives - LW'(1);
                  idx_nxt   = '0;
                  state_nxt = PLAYBACK;
               end else begin
                  idx_nxt   = '0;
                  state_nxt = DONE;
               end
            end
            DONE, WIN: begin
               idx_nxt = at_last ? '0 : idx + IW'(1);
            end
            default: begin
               state_nxt = INPUT;
               len_nxt   = '0;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   always_comb begin
      mode_leds    = LED_MODE_INPUT;
      pattern_leds = pattern;
      case (state)
         INPUT:    mode_leds = LED_MODE_INPUT;
         REPEAT:   mode_leds = LED_MODE_REPEAT;
         PLAYBACK: begin
            mode_leds    = LED_MODE_PLAYBACK;
            pattern_leds = mem_rdata;
         end
         DONE: begin
            mode_leds    = LED_MODE_DONE;
            pattern_leds = mem_rdata;
         end
         WIN: begin
            mode_leds    = LED_MODE_WIN;
            pattern_leds = mem_rdata;
         end
         default: mode_leds = LED_MODE_INPUT;
      endcase
   end

   assign score      = len;
   assign lives_left = lives;

`ifdef SIMON_HISCORE_EN
   logic game_over_edge;

   // Only the transition into a terminal state updates the record.
   assign game_over_edge = ((state_nxt == DONE) || (state_nxt == WIN)) &&
                           (state != DONE) && (state != WIN);

   always_ff @(posedge pclk or negedge rst) begin
      if (!rst)
         hiscore <= '0;
      else if (game_over_edge && (len > hiscore))
         hiscore <= len;
   end
`endif

endmodule

// File: tb/tb_simon_multi.sv
// Self-checking bench for simon_multi (WIDTH=4, DEPTH=4, LIVES=1): directed
// scenarios plus randomized play against a queue-based game model.
module tb_simon_multi;

   localparam int WIDTH = 4;
   localparam int DEPTH = 4;
   localparam int LIVES = 1;

   localparam int P_IN = 0, P_PB = 1, P_RP = 2, P_DN = 3, P_WN = 4;

   logic       pclk = 1'b0;
   logic       rst;
   logic       new_game;
   logic       level;
   logic [3:0] pattern;
   logic [3:0] pattern_leds;
   logic [2:0] mode_leds;
   logic [2:0] score;
   logic [0:0] lives_left;
`ifdef SIMON_HISCORE_EN
   logic [2:0] hiscore;
`endif

   simon_multi #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LIVES(LIVES)) dut (
      .pclk         (pclk),
      .rst          (rst),
      .new_game     (new_game),
      .level        (level),
      .pattern      (pattern),
      .pattern_leds (pattern_leds),
      .mode_leds    (mode_leds),
      .score        (score),
      .lives_left   (lives_left)
`ifdef SIMON_HISCORE_EN
      ,
      .hiscore      (hiscore)
`endif
   );

   always #5 pclk = ~pclk;

   // Game model: the recorded sequence, the phase of play and a cursor.
   int m_seq[$];
   int m_phase;
   int m_idx;
   int m_lives;
   int m_hi;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   bit pin_en = 1'b0;
   int pin_mode, pin_pleds, pin_score, pin_lives;

   function automatic int exp_mode();
      case (m_phase)
         P_IN:    return 1;
         P_PB:    return 2;
         P_RP:    return 4;
         P_DN:    return 7;
         default: return 3;
      endcase
   endfunction

   function automatic int exp_pleds();
      if (m_phase == P_IN || m_phase == P_RP)
         return int'(pattern);
      return m_seq[m_idx];
   endfunction

   task automatic model_reset();
      m_seq.delete();
      m_phase = P_IN;
      m_idx   = 0;
      m_lives = LIVES;
   endtask

   task automatic model_edge(input logic [3:0] p, input logic l, input logic ng);
      int n;
      n = m_seq.size();
      if (ng) begin
         model_reset();
         return;
      end
      case (m_phase)
         P_IN: begin
            if (p != 0 && (!l || $countones(p) == 1) && n < DEPTH) begin
               m_seq.push_back(int'(p));
               m_idx   = 0;
               m_phase = P_PB;
            end
         end
         P_PB: begin
            m_idx++;
            if (m_idx == n) begin
               m_idx   = 0;
               m_phase = P_RP;
            end
         end
         P_RP: begin
            if (int'(p) == m_seq[m_idx]) begin
               m_idx++;
               if (m_idx == n) begin
                  m_idx   = 0;
                  m_phase = (n == DEPTH) ? P_WN : P_IN;
                  if (m_phase == P_WN && n > m_hi) m_hi = n;
               end
            end else if (m_lives > 0) begin
               m_lives--;
               m_idx   = 0;
               m_phase = P_PB;
            end else begin
               m_idx   = 0;
               m_phase = P_DN;
               if (n > m_hi) m_hi = n;
            end
         end
         default: m_idx = (m_idx + 1) % n;
      endcase
   endtask

   task automatic check(input string name, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
      end
   endtask

   // Single compare process: model and literal pins against the DUT.
   always @(negedge pclk) begin
      if (chk_en) begin
         check("mode_leds", int'(mode_leds), exp_mode());
         check("pattern_leds", int'(pattern_leds), exp_pleds());
         check("score", int'(score), m_seq.size());
         check("lives_left", int'(lives_left), m_lives);
`ifdef SIMON_HISCORE_EN
         check("hiscore", int'(hiscore), m_hi);
`endif
      end
      if (pin_en) begin
         check("pin_mode", int'(mode_leds), pin_mode);
         check("pin_pleds", int'(pattern_leds), pin_pleds);
         check("pin_score", int'(score), pin_score);
         check("pin_lives", int'(lives_left), pin_lives);
      end
   end

   task automatic press(input logic [3:0] p, input logic l, input logic ng);
      pattern  = p;
      level    = l;
      new_game = ng;
      @(posedge pclk);
      #1;
      model_edge(p, l, ng);
      new_game = 1'b0;
   endtask

   task automatic pin(input int md, input int pl, input int sc, input int lv);
      pin_mode  = md;
      pin_pleds = pl;
      pin_score = sc;
      pin_lives = lv;
      pin_en    = 1'b1;
      @(negedge pclk);
      #1;
      pin_en = 1'b0;
   endtask

   // One full round: record p, step through playback, repeat correctly.
   task automatic round(input logic [3:0] p);
      int n;
      press(p, 1'b0, 1'b0);
      n = m_seq.size();
      for (int i = 0; i < n; i++) press(4'b0000, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) press(4'(m_seq[i]), 1'b0, 1'b0);
   endtask

   initial begin
      logic [3:0] rp;
      logic       rl, rg;
      int         r;

      rst      = 1'b0;
      new_game = 1'b0;
      level    = 1'b0;
      pattern  = 4'b0101;
      m_hi     = 0;
      model_reset();
      chk_en   = 1'b1;

      // Reset state shows live switches in INPUT.
      pin(1, 4'b0101, 0, 1);
      rst = 1'b1;

      press(4'b0101, 1'b0, 1'b0);
      pin(2, 4'b0101, 1, 1);
      press(4'b0000, 1'b0, 1'b0);
      pin(4, 4'b0000, 1, 1);
      press(4'b0101, 1'b0, 1'b0);
      pin(1, 4'b0101, 1, 1);

      // Hard level rejects a two-bit pattern, accepts a one-hot one.
      press(4'b1010, 1'b1, 1'b0);
      pin(1, 4'b1010, 1, 1);
      press(4'b0000, 1'b0, 1'b0);
      pin(1, 4'b0000, 1, 1);
      press(4'b1000, 1'b1, 1'b0);
      pin(2, 4'b0101, 2, 1);
      press(4'b0000, 1'b0, 1'b0);
      pin(2, 4'b1000, 2, 1);
      press(4'b0000, 1'b0, 1'b0);
      pin(4, 4'b0000, 2, 1);

      // Wrong guess costs a life and replays; second one ends the game.
      press(4'b0010, 1'b0, 1'b0);
      pin(2, 4'b0101, 2, 0);
      press(4'b0000, 1'b0, 1'b0);
      press(4'b0000, 1'b0, 1'b0);
      pin(4, 4'b0000, 2, 0);
      press(4'b0101, 1'b0, 1'b0);
      press(4'b0011, 1'b0, 1'b0);
      pin(7, 4'b0101, 2, 0);
      press(4'b0000, 1'b0, 1'b0);
      pin(7, 4'b1000, 2, 0);
      press(4'b0000, 1'b0, 1'b0);
      pin(7, 4'b0101, 2, 0);

      // new_game while in REPEAT with score 2.
      press(4'b0000, 1'b0, 1'b1);
      round(4'b0110);
      press(4'b0001, 1'b0, 1'b0);
      press(4'b0000, 1'b0, 1'b0);
      press(4'b0000, 1'b0, 1'b0);
      pin(4, 4'b0000, 2, 1);
      press(4'b0000, 1'b0, 1'b1);
      pin(1, 4'b0000, 0, 1);

      // Four correct rounds fill the memory and win.
      round(4'b0011);
      round(4'b1000);
      round(4'b0110);
      round(4'b0001);
      pin(3, 4'b0011, 4, 1);
      press(4'b0000, 1'b0, 1'b0);
      pin(3, 4'b1000, 4, 1);
      press(4'b0000, 1'b0, 1'b0);
      press(4'b0000, 1'b0, 1'b0);
      press(4'b0000, 1'b0, 1'b0);
      pin(3, 4'b0011, 4, 1);

      // Asynchronous reset in PLAYBACK, between clock edges.
      press(4'b0000, 1'b0, 1'b1);
      press(4'b0101, 1'b0, 1'b0);
      #2;
      rst = 1'b0;
      m_hi = 0;
      model_reset();
      pin(1, 4'b0101, 0, 1);
      rst = 1'b1;

      // Randomized play.
      for (int i = 0; i < 800; i++) begin
         r  = int'($urandom_range(0, 99));
         rg = (r < 3) || ((m_phase == P_DN || m_phase == P_WN) && r < 30);
         rl = 1'($urandom_range(0, 1));
         rp = 4'($urandom_range(0, 15));
         if (m_phase == P_RP && $urandom_range(0, 9) < 8)
            rp = 4'(m_seq[m_idx]);
         else if (m_phase == P_IN && $urandom_range(0, 1) == 0)
            rp = 4'(1 << $urandom_range(0, 3));
         press(rp, rl, rg);
      end

      @(negedge pclk);
      #1;
      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
